// File: rtl/gpr_file_sb_pkg.sv
// rtl/gpr_file_sb_pkg.sv - shared CPU defines for the GPR file and write-back scoreboard
package gpr_file_sb_pkg;
   localparam int CPU_XLEN = 64;
   localparam int CPU_NREG = 32;
   localparam int WP_ALU   = 0;
   localparam int WP_LSU   = 1;
   localparam int NWP      = 2;

   typedef logic [1:0] sb_cnt_t;
   localparam sb_cnt_t SB_CNT_MAX = 2'd3;
endpackage

// File: rtl/gpr_sb_cnt.sv
// rtl/gpr_sb_cnt.sv - per-register pending write-back counter, clamped to 0..3
module gpr_sb_cnt
   import gpr_file_sb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_inc,
   input  logic [1:0] i_dec,
   output logic [1:0] o_cnt,
   output logic       o_under
);

   logic [1:0] r_cnt;
   logic [2:0] w_sum;
   logic [2:0] w_diff;
   logic [1:0] w_next;

   always_comb begin
      w_sum   = {1'b0, r_cnt} + {2'b00, i_inc};
      w_diff  = w_sum - {1'b0, i_dec};
      o_under = (w_sum < {1'b0, i_dec});
      if (o_under)
         w_next = 2'd0;
      else if (w_diff > {1'b0, SB_CNT_MAX})
         w_next = SB_CNT_MAX;
      else
         w_next = w_diff[1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= 2'd0;
      else
         r_cnt <= w_next;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - register file with ALU/LSU write-back, bypassed reads and issue scoreboard
module gpr_file_sb
   import gpr_file_sb_pkg::*;
#(
   parameter int XLEN = CPU_XLEN,
   parameter int NREG = CPU_NREG,
   parameter int NRD  = 2,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          wr_en,
   input  logic [2*AW-1:0]     wr_addr,
   input  logic [2*XLEN-1:0]   wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic                iss_ready,
   output logic                sb_err
);

   logic                r_live;
   logic                r_sb_err;
   logic [XLEN-1:0]     r_regs [NREG];
   logic [NWP-1:0]      w_wen;
   logic [AW-1:0]       w_waddr [NWP];
   logic [XLEN-1:0]     w_wdata [NWP];
   logic [1:0]          w_cnt [NREG];
   logic [1:0]          w_dec [NREG];
   logic [NREG-1:0]     w_inc;
   logic [NREG-1:0]     w_under;
   logic                w_iss_hit;
   logic                w_iss_fire;

   // r_live stays low through the first edge after reset release, so that cycle's traffic is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_live <= 1'b0;
      else
         r_live <= 1'b1;
   end

   // x0 writes are masked here so nothing downstream needs to special-case them
   always_comb begin
      for (int p = 0; p < NWP; p++) begin
         w_waddr[p] = wr_addr[p*AW +: AW];
         w_wdata[p] = wr_data[p*XLEN +: XLEN];
         w_wen[p]   = wr_en[p] && r_live && (wr_addr[p*AW +: AW] != '0);
      end
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         w_dec[r] = {1'b0, w_wen[WP_ALU] && (w_waddr[WP_ALU] == AW'(r))}
                  + {1'b0, w_wen[WP_LSU] && (w_waddr[WP_LSU] == AW'(r))};
      end
   end

   assign w_iss_hit  = (w_wen[WP_ALU] && (w_waddr[WP_ALU] == iss_rd))
                    || (w_wen[WP_LSU] && (w_waddr[WP_LSU] == iss_rd));
   assign iss_ready  = !((w_cnt[iss_rd] == SB_CNT_MAX) && !w_iss_hit);
   assign w_iss_fire = iss_valid && iss_ready && r_live && (iss_rd != '0);
   assign w_inc      = w_iss_fire ? (NREG'(1) << iss_rd) : '0;

   for (genvar g = 0; g < NREG; g++) begin : g_cnt
      gpr_sb_cnt u_cnt (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_inc   (w_inc[g]),
         .i_dec   (w_dec[g]),
         .o_cnt   (w_cnt[g]),
         .o_under (w_under[g])
      );
   end

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0]   v_a;
         logic [XLEN-1:0] v_d;
         logic [1:0]      v_hits;
         v_a    = rd_addr[i*AW +: AW];
         v_d    = r_regs[v_a];
         v_hits = {1'b0, w_wen[WP_ALU] && (w_waddr[WP_ALU] == v_a)}
                + {1'b0, w_wen[WP_LSU] && (w_waddr[WP_LSU] == v_a)};
         if (w_wen[WP_ALU] && (w_waddr[WP_ALU] == v_a)) v_d = w_wdata[WP_ALU];
         if (w_wen[WP_LSU] && (w_waddr[WP_LSU] == v_a)) v_d = w_wdata[WP_LSU];
         if (v_a == '0) v_d = '0;
         rd_data[i*XLEN +: XLEN] = v_d;
         rd_busy[i] = (v_a != '0) && (w_cnt[v_a] > v_hits);
      end
   end

   // LSU is written after ALU so it wins on a same-address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      end else begin
         for (int p = 0; p < NWP; p++)
            if (w_wen[p]) r_regs[w_waddr[p]] <= w_wdata[p];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sb_err <= 1'b0;
      else
         r_sb_err <= r_sb_err | (|w_under);
   end

   assign sb_err = r_sb_err;

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - scoreboard bench for gpr_file_sb against a behavioural register/scoreboard model
module tb_gpr_file_sb;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [1:0]          wr_en = '0;
   logic [2*AW-1:0]     wr_addr = '0;
   logic [2*XLEN-1:0]   wr_data = '0;
   logic [NRD*AW-1:0]   rd_addr = '0;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_valid = 1'b0;
   logic [AW-1:0]       iss_rd = '0;
   logic                iss_ready;
   logic                sb_err;

   gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .sb_err    (sb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string                name;
      logic [NRD*XLEN-1:0]  data;
      logic [NRD-1:0]       busy;
      logic                 rdy;
      logic                 err;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [XLEN-1:0] m_regs [NREG];
   int              m_cnt  [NREG];
   bit              m_err;
   bit              m_live;

   task automatic model_clear();
      for (int r = 0; r < NREG; r++) begin
         m_regs[r] = '0;
         m_cnt[r]  = 0;
      end
      m_err  = 1'b0;
      m_live = 1'b0;
   endtask

   // Drives one cycle at the falling edge, pushes what the outputs must be, then advances the model past the next rising edge.
   task automatic cycle(input string name, input bit rst, input logic [1:0] we,
                        input int wa0, input int wa1,
                        input logic [XLEN-1:0] wd0, input logic [XLEN-1:0] wd1,
                        input int ra0, input int ra1, input bit iv, input int ird);
      exp_t e;
      int   ra [NRD];
      int   wa [2];
      logic [XLEN-1:0] wd [2];
      bit   en [2];
      int   hits;
      int   nxt;
      @(negedge clk);
      rst_n     = !rst;
      wr_en     = we;
      wr_addr   = {AW'(wa1), AW'(wa0)};
      wr_data   = {wd1, wd0};
      rd_addr   = {AW'(ra1), AW'(ra0)};
      iss_valid = iv;
      iss_rd    = AW'(ird);
      if (rst) model_clear();
      ra[0] = ra0; ra[1] = ra1;
      wa[0] = wa0; wa[1] = wa1;
      wd[0] = wd0; wd[1] = wd1;
      for (int p = 0; p < 2; p++) en[p] = we[p] && m_live && !rst && (wa[p] != 0);
      e.name = name;
      for (int i = 0; i < NRD; i++) begin
         logic [XLEN-1:0] v;
         hits = 0;
         for (int p = 0; p < 2; p++) if (en[p] && wa[p] == ra[i]) hits++;
         if (ra[i] == 0)                     v = '0;
         else if (en[1] && wa[1] == ra[i])   v = wd[1];
         else if (en[0] && wa[0] == ra[i])   v = wd[0];
         else                                v = m_regs[ra[i]];
         e.data[i*XLEN +: XLEN] = v;
         e.busy[i] = (ra[i] != 0) && (m_cnt[ra[i]] - hits > 0);
      end
      hits = 0;
      for (int p = 0; p < 2; p++) if (en[p] && wa[p] == ird) hits++;
      e.rdy = !(m_cnt[ird] == 3 && hits == 0);
      e.err = m_err;
      exp_q.push_back(e);
      if (!rst) begin
         for (int r = 1; r < NREG; r++) begin
            nxt = m_cnt[r];
            if (iv && e.rdy && m_live && ird == r) nxt++;
            for (int p = 0; p < 2; p++) if (en[p] && wa[p] == r) nxt--;
            if (nxt < 0) begin
               nxt   = 0;
               m_err = 1'b1;
            end
            if (nxt > 3) nxt = 3;
            m_cnt[r] = nxt;
         end
         for (int p = 0; p < 2; p++) if (en[p]) m_regs[wa[p]] = wd[p];
         m_live = 1'b1;
      end
   endtask

   task automatic check(input string name, input string field,
                        input logic [NRD*XLEN-1:0] act, input logic [NRD*XLEN-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, "rd_data", rd_data, e.data);
            check(e.name, "rd_busy", {{(NRD*XLEN-NRD){1'b0}}, rd_busy}, {{(NRD*XLEN-NRD){1'b0}}, e.busy});
            check(e.name, "iss_ready", {{(NRD*XLEN-1){1'b0}}, iss_ready}, {{(NRD*XLEN-1){1'b0}}, e.rdy});
            check(e.name, "sb_err", {{(NRD*XLEN-1){1'b0}}, sb_err}, {{(NRD*XLEN-1){1'b0}}, e.err});
         end
      end
   end

   initial begin
      logic [XLEN-1:0] r0, r1;
      model_clear();
      cycle("reset0", 1, 2'b00, 0, 0, '0, '0, 5, 7, 0, 0);
      cycle("reset1", 1, 2'b11, 1, 2, 64'h55, 64'h66, 1, 2, 1, 4);
      cycle("release_drop", 0, 2'b01, 1, 0, 64'hDEAD, '0, 1, 0, 1, 4);
      cycle("release_chk", 0, 2'b00, 0, 0, '0, '0, 1, 4, 0, 0);
      cycle("x5_bypass", 0, 2'b01, 5, 0, 64'h1234, '0, 5, 0, 0, 0);
      cycle("x5_read", 0, 2'b00, 0, 0, '0, '0, 5, 5, 0, 0);
      cycle("x7_both", 0, 2'b11, 7, 7, 64'hAA, 64'hBB, 7, 0, 0, 0);
      cycle("x7_read", 0, 2'b00, 0, 0, '0, '0, 7, 7, 0, 0);
      cycle("x0_write", 0, 2'b01, 0, 0, 64'hFFFF, '0, 0, 0, 1, 0);
      cycle("x0_read", 0, 2'b00, 0, 0, '0, '0, 0, 0, 1, 0);
      cycle("x3_iss1", 0, 2'b00, 0, 0, '0, '0, 3, 0, 1, 3);
      cycle("x3_iss2", 0, 2'b00, 0, 0, '0, '0, 3, 0, 1, 3);
      cycle("x3_iss3", 0, 2'b00, 0, 0, '0, '0, 3, 0, 1, 3);
      cycle("x3_full", 0, 2'b00, 0, 0, '0, '0, 3, 0, 1, 3);
      cycle("x3_lsu_wb", 0, 2'b10, 0, 3, '0, 64'h33, 3, 0, 1, 3);
      cycle("x3_still3", 0, 2'b00, 0, 0, '0, '0, 3, 3, 1, 3);
      cycle("x9_under", 0, 2'b01, 9, 0, 64'h99, '0, 9, 0, 0, 0);
      cycle("x9_read", 0, 2'b00, 0, 0, '0, '0, 9, 3, 0, 0);
      for (int k = 0; k < 4; k++) cycle("err_sticky", 0, 2'b00, 0, 0, '0, '0, 9, 5, 0, 0);
      cycle("mid_reset", 1, 2'b00, 0, 0, '0, '0, 3, 5, 1, 3);
      cycle("after_reset", 0, 2'b00, 0, 0, '0, '0, 3, 9, 1, 3);
      for (int k = 0; k < 3000; k++) begin
         int a [6];
         for (int j = 0; j < 6; j++)
            a[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG-1)) : int'($urandom_range(0, 7));
         r0 = {$urandom, $urandom};
         r1 = {$urandom, $urandom};
         cycle("rand", ($urandom_range(0, 299) == 0), 2'($urandom_range(0, 3)), a[0], a[1], r0, r1,
               a[2], a[3], ($urandom_range(0, 2) != 0), a[4]);
      end
      cycle("drain", 0, 2'b00, 0, 0, '0, '0, 0, 0, 0, 0);
      @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/gpr_file_sb.md
GPR_FILE_SB -- requirements
Module: gpr_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning register data width.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  2  write enable; port 0 is ALU write-back, port 1 is LSU write-back.
REQ-007 SHALL have port wr_addr  input  2*AW  write addresses, port p in slice p.
REQ-008 SHALL have port wr_data  input  2*XLEN  write data, port p in slice p.
REQ-009 SHALL have port rd_addr  input  NRD*AW  read addresses.
REQ-010 SHALL have port rd_data  output  NRD*XLEN  read data.
REQ-011 SHALL have port rd_busy  output  NRD  read register still has pending writes after this cycle's write-backs.
REQ-012 SHALL have port iss_valid  input  1  issue request reserving destination iss_rd.
REQ-013 SHALL have port iss_rd  input  AW  issue destination register.
REQ-014 SHALL have port iss_ready  output  1  issue accepted when iss_valid and iss_ready are both high.
REQ-015 SHALL have port sb_err  output  1  sticky scoreboard underflow flag.

Function
REQ-016 SHALL hold x0 at zero: reads return 0, writes to x0 are ignored, and issue to x0 never changes scoreboard state.
REQ-017 SHALL write registers on the rising clk edge; when both ports target the same nonzero address, port 1 data SHALL win.
REQ-018 SHALL read combinationally with same-cycle bypass: a matching enabled write forwards wr_data, port 1 over port 0, over stored value.
REQ-019 SHALL keep a 2-bit pending counter per register (0..3 outstanding writes).
REQ-020 SHALL update counter next = cur + (issue accepted to that reg) - (number of enabled write ports to that reg), all in one edge.
REQ-021 SHALL drive iss_ready low only when the counter of iss_rd equals 3 and no write to iss_rd occurs this cycle; otherwise high.
REQ-022 SHALL, when a decrement would make a counter negative, clamp it at 0, set sb_err, and still perform the data write.
REQ-023 SHALL drive rd_busy[i] high iff the rd_addr[i] counter minus same-cycle writes to it is nonzero; rd_busy SHALL be 0 for x0.
REQ-024 SHALL keep sb_err set until reset.
REQ-025 SHALL provide zero-latency read data and one-cycle latency for counter updates.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all registers, all counters and sb_err to 0; iss_ready SHALL be 1 and rd_busy 0.
REQ-027 SHALL discard any write or issue presented in the cycle that reset is released.

Structure
REQ-028 SHALL take XLEN, NREG defaults and the write-port indices (ALU=0, LSU=1) from the shared CPU defines package.
REQ-029 SHALL instantiate one sub-module gpr_sb_cnt per register holding the saturating counter; the data array SHALL stay in gpr_file_sb.

Verification
REQ-030 SHALL cover: write x5=0x1234 via port 0, read x5 next cycle -> rd_data 0x1234; same-cycle read -> 0x1234 via bypass.
REQ-031 SHALL cover: both ports write x7 (0xAA port 0, 0xBB port 1) -> x7 reads 0xBB.
REQ-032 SHALL cover: write 0xFFFF to x0 and issue to x0 -> rd_data 0, rd_busy 0, iss_ready 1.
REQ-033 SHALL cover: three issues to x3 -> rd_busy 1, iss_ready 0 on fourth; simultaneous LSU write to x3 -> iss_ready 1, counter stays 3.
REQ-034 SHALL cover: write x9 with counter 0 -> x9 updated, sb_err 1 and sticky until reset.
REQ-035 SHALL cover: rst_n low mid-operation with counters nonzero -> all reads 0, rd_busy 0, sb_err 0 immediately.
